// File: rtl/store_rmw_unit_pkg.sv
// Shared types and helpers for the store read-modify-write unit.
// The misalignment helper is only consulted when STORE_MISALIGN_CHECK_EN is defined.
package store_rmw_unit_pkg;

  localparam int DW = 64;

  typedef enum logic [2:0] {
    ST_SD = 3'd0,
    ST_SW = 3'd1,
    ST_SH = 3'd2,
    ST_SB = 3'd3
  } store_type_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Byte offset actually used for the merge: sub-fields snap down to their natural alignment.
  function automatic logic [2:0] eff_offset(input logic [2:0] st, input logic [2:0] off);
    logic [2:0] res;
    case (st)
      ST_SB:   res = off;
      ST_SH:   res = off & 3'b110;
      ST_SW:   res = off & 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic misaligned(input logic [2:0] st, input logic [2:0] off);
    logic res;
    case (st)
      ST_SH:   res = off[0];
      ST_SW:   res = (off[1:0] != 2'b00);
      ST_SD:   res = (off != 3'b000);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte-lane merger: overlays the stored field onto the old doubleword.
module store_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [DW-1:0] old_data,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    st,
  input  logic [2:0]    offset,
  output logic [DW-1:0] merged
);

  logic [7:0]    lane_mask;
  logic [7:0]    byte_en;
  logic [DW-1:0] data_sh;

  // Lane enables from the store size, shifted to the target offset.
  always_comb begin
    case (st)
      ST_SD:   lane_mask = 8'hFF;
      ST_SW:   lane_mask = 8'h0F;
      ST_SH:   lane_mask = 8'h03;
      ST_SB:   lane_mask = 8'h01;
      default: lane_mask = 8'h00;
    endcase
    byte_en = lane_mask << offset;
    data_sh = wdata << {offset, 3'b000};
    merged  = old_data;
    for (int b = 0; b < 8; b++) begin
      if (byte_en[b]) begin
        merged[8*b +: 8] = data_sh[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path: sd writes directly, sw/sh/sb read-modify-write the enclosing doubleword.
// Build option STORE_MISALIGN_CHECK_EN rejects misaligned sh/sw/sd instead of aligning them.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [2:0]    store_type,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [2:0]    type_q, type_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] merge_q, merge_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          mem_wr_q, mem_wr_d;
  logic          reject_s;
  logic [2:0]    offset_s;
  logic [DW-1:0] merged_s;

  assign offset_s = eff_offset(type_q, addr_q[2:0]);

  store_merge u_merge (
    .old_data (mem_rdata),
    .wdata    (wdata_q),
    .st       (type_q),
    .offset   (offset_s),
    .merged   (merged_s)
  );

  // Request screening: reserved types always, misalignment only when checking is built in.
  always_comb begin
`ifdef STORE_MISALIGN_CHECK_EN
    reject_s = store_type[2] | misaligned(store_type, addr[2:0]);
`else
    reject_s = store_type[2];
`endif
  end

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && reject_s) begin
          err_d = 1'b1;
        end else if (req) begin
          type_d  = store_type;
          addr_d  = addr;
          wdata_d = wdata;
          if (store_type == ST_SD) begin
            merge_d = wdata;
            state_d = S_WRITE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (cnt_q == 2'd0) begin
          merge_d = merged_s;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    mem_wr_d = (state_d == S_WRITE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      type_q   <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = {addr_q[DW-1:3], 3'b000};
  assign mem_wdata = merge_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Randomized bench for store_rmw_unit with RD_LAT=1 and RD_LAT=3 instances and a byte-level memory model.
module tb_store_rmw_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic [2:0]  st [2];
  logic [63:0] addr [2];
  logic [63:0] wdata [2];
  logic [63:0] mem_rdata [2];
  logic [63:0] mem_addr [2];
  logic [63:0] mem_wdata [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];
  logic        mem_wr [2];

  logic [63:0] mem [2][32];
  logic [63:0] ref_mem [2][32];
  int          age [2];
  logic        pre_we;
  int          pre_u;
  int          pre_idx;
  logic [63:0] pre_val;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  store_rmw_unit #(.RD_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .store_type(st[0]), .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wr(mem_wr[0]), .mem_rdata(mem_rdata[0]));

  store_rmw_unit #(.RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .store_type(st[1]), .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wr(mem_wr[1]), .mem_rdata(mem_rdata[1]));

  // Memory: data is only valid once the address has been held for the read latency.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age[0] <= 0;
      age[1] <= 0;
    end else begin
      if (pre_we) mem[pre_u][pre_idx] <= pre_val;
      for (int u = 0; u < 2; u++) begin
        if (mem_wr[u]) mem[u][mem_addr[u][7:3]] <= mem_wdata[u];
        age[u] <= busy[u] ? age[u] + 1 : 0;
      end
    end
  end

  assign mem_rdata[0] = (age[0] >= LAT0 - 1) ? mem[0][mem_addr[0][7:3]] : ~mem[0][mem_addr[0][7:3]];
  assign mem_rdata[1] = (age[1] >= LAT1 - 1) ? mem[1][mem_addr[1][7:3]] : ~mem[1][mem_addr[1][7:3]];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int u, input int idx, input logic [63:0] v);
    @(negedge clk);
    pre_u = u; pre_idx = idx; pre_val = v; pre_we = 1'b1;
    ref_mem[u][idx] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One store through unit u, with input noise while busy, checked against byte-level expectations.
  task automatic do_store(input int u, input logic [2:0] ty, input logic [63:0] a, input logic [63:0] d);
    int lat, n, o, idx, exp_wr, exp_done;
    int wr_c, done_c, err_c, wr_n, done_n;
    bit rej;
    logic busy1;
    logic [63:0] wa, wd;
    lat = (u == 0) ? LAT0 : LAT1;
    n   = (ty == 3'd0) ? 8 : (ty == 3'd1) ? 4 : (ty == 3'd2) ? 2 : 1;
    o   = int'(a[2:0]);
    idx = int'(a[7:3]);
    rej = (ty > 3'd3);
`ifdef STORE_MISALIGN_CHECK_EN
    if (!rej && (o % n) != 0) rej = 1'b1;
`endif
    o = o - (o % n);
    exp_wr   = rej ? -1 : ((ty == 3'd0) ? 1 : lat + 1);
    exp_done = rej ? -1 : exp_wr + 1;
    wr_c = -1; done_c = -1; err_c = -1; wr_n = 0; done_n = 0;
    busy1 = 1'b0; wa = '0; wd = '0;
    @(negedge clk);
    req[u] = 1'b1; st[u] = ty; addr[u] = a; wdata[u] = d;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wr[u]) begin
        wr_n++;
        if (wr_c < 0) begin wr_c = c; wa = mem_addr[u]; wd = mem_wdata[u]; end
      end
      if (done[u]) begin done_n++; if (done_c < 0) done_c = c; end
      if (err[u] && err_c < 0) err_c = c;
      if (c == 1) busy1 = busy[u];
      if (c < exp_done) begin
        req[u] = 1'($urandom); st[u] = 3'($urandom);
        addr[u] = {$urandom, $urandom}; wdata[u] = {$urandom, $urandom};
      end else begin
        req[u] = 1'b0;
      end
    end
    check_val("wr_cycle", 64'(wr_c), 64'(exp_wr));
    check_val("wr_count", 64'(wr_n), rej ? 64'd0 : 64'd1);
    check_val("done_cycle", 64'(done_c), 64'(exp_done));
    check_val("done_count", 64'(done_n), rej ? 64'd0 : 64'd1);
    check_val("err_cycle", 64'(err_c), rej ? 64'd1 : -64'sd1);
    check_val("busy", {63'd0, busy1}, {63'd0, ~rej});
    if (!rej) begin
      for (int i = 0; i < n; i++) ref_mem[u][idx][8*(o+i) +: 8] = d[8*i +: 8];
      check_val("mem_addr", wa, {56'd0, a[7:3], 3'b000});
      check_val("mem_wdata", wd, ref_mem[u][idx]);
    end
    check_val("mem_word", mem[u][idx], ref_mem[u][idx]);
  endtask

  // Reset in the middle of a READ on the RD_LAT=3 unit must abandon the store.
  task automatic reset_mid_read();
    int bad;
    @(negedge clk);
    req[1] = 1'b1; st[1] = 3'd3; addr[1] = 64'h40; wdata[1] = 64'h5A;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_busy", {63'd0, busy[1]}, 64'd0);
    check_val("rst_mem_wr", {63'd0, mem_wr[1]}, 64'd0);
    check_val("rst_mem_addr", mem_addr[1], 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy[1] || mem_wr[1] || done[1] || err[1] || mem_wdata[1] != 64'd0) bad++;
    end
    check_val("rst_quiet", 64'(bad), 64'd0);
    check_val("rst_mem_word", mem[1][8], ref_mem[1][8]);
  endtask

  initial begin
    rst = 1'b0; pre_we = 1'b0; pre_u = 0; pre_idx = 0; pre_val = '0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; st[u] = 3'd0; addr[u] = '0; wdata[u] = '0;
    end
    repeat (3) @(negedge clk);
    check_val("reset_outs", {58'd0, busy[0], done[0], err[0], mem_wr[0], busy[1], mem_wr[1]}, 64'd0);
    check_val("reset_addr", mem_addr[0] | mem_addr[1], 64'd0);
    check_val("reset_wdata", mem_wdata[0] | mem_wdata[1], 64'd0);
    rst = 1'b1;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 32; i++) preload(u, i, {$urandom, $urandom});

    do_store(0, 3'd0, 64'h10, 64'h1122334455667788);
    check_val("sd_word", mem[0][2], 64'h1122334455667788);
    preload(0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_store(0, 3'd3, 64'h0B, 64'hAB);
    check_val("sb_word", mem[0][1], 64'hFFFF_FFFF_ABFF_FFFF);
    preload(1, 2, 64'd0);
    do_store(1, 3'd2, 64'h16, 64'hBEEF);
    check_val("sh_word", mem[1][2], 64'hBEEF_0000_0000_0000);
    preload(0, 4, 64'd0);
    do_store(0, 3'd1, 64'h23, 64'hDEADBEEF);
`ifdef STORE_MISALIGN_CHECK_EN
    check_val("sw_mis_word", mem[0][4], 64'd0);
`else
    check_val("sw_mis_word", mem[0][4], 64'h0000_0000_DEAD_BEEF);
`endif
    do_store(0, 3'd5, 64'h30, 64'h0123456789ABCDEF);
    reset_mid_read();

    for (int k = 0; k < 80; k++) begin
      int u;
      logic [2:0] ty;
      u  = int'($urandom_range(0, 1));
      ty = 3'($urandom_range(0, 4));
      if (ty == 3'd4) ty = 3'($urandom_range(4, 7));
      do_store(u, ty, 64'($urandom_range(0, 255)), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
